// File: rtl/boot_loader.sv
// UART boot-protocol responder: loads checksummed word frames into memory,
// then releases the core from reset at the requested start PC.
module boot_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 2500000,
    parameter logic [7:0]  CMD_LOAD       = 8'h10,
    parameter logic [7:0]  CMD_START      = 8'h20
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rx_fresh,
    input  logic [7:0]  i_rx_data,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ack,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_mem_we,
    input  logic        i_mem_ack,
    output logic        o_core_rst,
    output logic [31:0] o_start_pc,
    output logic        o_busy
);

    // Handshakes: o_mem_we/o_mem_addr/o_mem_wdata hold until i_mem_ack is seen
    // high on a clock edge; o_tx_valid/o_tx_data hold until i_tx_ack likewise.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_L_SIZE,
        ST_L_ADDR,
        ST_L_SUM,
        ST_L_DATA,
        ST_L_WRITE,
        ST_L_CHECK,
        ST_STATUS,
        ST_S_ADDR,
        ST_RUN
    } state_t;

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] field_q, field_d;
    logic [31:0] size_q, size_d;
    logic [31:0] base_q, base_d;
    logic [31:0] chk_q, chk_d;
    logic [31:0] sum_q, sum_d;
    logic [31:0] idx_q, idx_d;
    logic [31:0] tmo_q, tmo_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_we_q, mem_we_d;
    logic        core_rst_q, core_rst_d;
    logic [31:0] start_pc_q, start_pc_d;

    logic [31:0] field_next;
    logic        timed;
    logic        last_byte;
    logic        tmo_hit;

    // Fields arrive little-endian, so each new byte shifts in from the top.
    assign field_next = {i_rx_data, field_q[31:8]};
    assign last_byte  = i_rx_fresh && (cnt_q == 2'd3);
    assign timed      = (state_q == ST_L_SIZE) || (state_q == ST_L_ADDR) ||
                        (state_q == ST_L_SUM)  || (state_q == ST_L_DATA) ||
                        (state_q == ST_S_ADDR);
    assign tmo_hit    = timed && !i_rx_fresh && (tmo_q >= TMO_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            field_q     <= '0;
            size_q      <= '0;
            base_q      <= '0;
            chk_q       <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            tmo_q       <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            core_rst_q  <= 1'b1;
            start_pc_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            field_q     <= field_d;
            size_q      <= size_d;
            base_q      <= base_d;
            chk_q       <= chk_d;
            sum_q       <= sum_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            core_rst_q  <= core_rst_d;
            start_pc_q  <= start_pc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        field_d     = field_q;
        size_d      = size_q;
        base_d      = base_q;
        chk_d       = chk_q;
        sum_d       = sum_q;
        idx_d       = idx_q;
        tmo_d       = '0;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        core_rst_d  = core_rst_q;
        start_pc_d  = start_pc_q;

        // Only field-collecting states accept bytes and run the idle timer.
        if (timed) begin
            tmo_d = i_rx_fresh ? '0 : tmo_q + 32'd1;
            if (i_rx_fresh) begin
                field_d = field_next;
                cnt_d   = cnt_q + 2'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (i_rx_fresh) begin
                    if (i_rx_data == CMD_LOAD) begin
                        state_d = ST_L_SIZE;
                    end else if (i_rx_data == CMD_START) begin
                        state_d = ST_S_ADDR;
                    end else begin
                        tx_data_d  = 8'hFF;
                        tx_valid_d = 1'b1;
                        state_d    = ST_STATUS;
                    end
                end
            end
            ST_L_SIZE: begin
                if (last_byte) begin
                    size_d  = field_next;
                    state_d = ST_L_ADDR;
                end
            end
            ST_L_ADDR: begin
                if (last_byte) begin
                    base_d  = {field_next[31:2], 2'b00};
                    state_d = ST_L_SUM;
                end
            end
            ST_L_SUM: begin
                if (last_byte) begin
                    chk_d   = field_next;
                    sum_d   = '0;
                    idx_d   = '0;
                    state_d = (size_q == 32'd0) ? ST_L_CHECK : ST_L_DATA;
                end
            end
            ST_L_DATA: begin
                if (last_byte) begin
                    mem_addr_d  = base_q + {idx_q[29:0], 2'b00};
                    mem_wdata_d = field_next;
                    mem_we_d    = 1'b1;
                    state_d     = ST_L_WRITE;
                end
            end
            ST_L_WRITE: begin
                if (i_mem_ack) begin
                    sum_d    = sum_q + mem_wdata_q;
                    idx_d    = idx_q + 32'd1;
                    mem_we_d = 1'b0;
                    state_d  = (idx_q + 32'd1 == size_q) ? ST_L_CHECK : ST_L_DATA;
                end
            end
            ST_L_CHECK: begin
                tx_data_d  = (sum_q == chk_q) ? 8'h01 : 8'h00;
                tx_valid_d = 1'b1;
                state_d    = ST_STATUS;
            end
            ST_STATUS: begin
                if (i_tx_ack) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            ST_S_ADDR: begin
                if (last_byte) begin
                    start_pc_d = {field_next[31:2], 2'b00};
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                // The PC register settles one cycle before the core is released.
                core_rst_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (tmo_hit) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            tmo_d    = '0;
            mem_we_d = 1'b0;
        end
    end

    assign o_tx_data   = tx_data_q;
    assign o_tx_valid  = tx_valid_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_mem_we    = mem_we_q;
    assign o_core_rst  = core_rst_q;
    assign o_start_pc  = start_pc_q;
    assign o_busy      = (state_q != ST_IDLE) && (state_q != ST_RUN);

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: frame-level model of expected writes and
// status bytes, with memory/UART responders that compare every transaction.
module tb_boot_loader;

  localparam int TMO = 40;
  localparam int GAP = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_rx_fresh;
  logic [7:0]  i_rx_data;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ack = 1'b0;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        o_mem_we;
  logic        i_mem_ack = 1'b0;
  logic        o_core_rst;
  logic [31:0] o_start_pc;
  logic        o_busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [31:0] frame_words[$];

  int          ack_delay = 0;
  int          tx_delay = 1;
  int          write_cnt = 0;
  logic [7:0]  last_tx = 8'h5A;
  bit          started = 1'b0;

  // clock / reset
  always #5 clk = ~clk;

  boot_loader #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx_fresh (i_rx_fresh),
    .i_rx_data  (i_rx_data),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_ack   (i_tx_ack),
    .o_mem_addr (o_mem_addr),
    .o_mem_wdata(o_mem_wdata),
    .o_mem_we   (o_mem_we),
    .i_mem_ack  (i_mem_ack),
    .o_core_rst (o_core_rst),
    .o_start_pc (o_start_pc),
    .o_busy     (o_busy)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // memory responder: compares each write on its first cycle, then checks hold
  logic        in_write = 1'b0;
  logic        acked = 1'b0;
  int          wait_cnt = 0;
  logic [31:0] hold_addr, hold_data;

  always @(negedge clk) begin
    i_mem_ack = 1'b0;
    if (rst) begin
      in_write = 1'b0;
    end else if (o_mem_we) begin
      if (!in_write) begin
        in_write  = 1'b1;
        acked     = 1'b0;
        wait_cnt  = 0;
        hold_addr = o_mem_addr;
        hold_data = o_mem_wdata;
        write_cnt++;
        if (exp_addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=%h/%h required=none", o_mem_addr, o_mem_wdata);
        end else begin
          check32("write_addr", o_mem_addr, exp_addr_q.pop_front());
          check32("write_data", o_mem_wdata, exp_data_q.pop_front());
        end
      end else begin
        check32("hold_addr", o_mem_addr, hold_addr);
        check32("hold_data", o_mem_wdata, hold_data);
      end
      if (wait_cnt == ack_delay) begin
        i_mem_ack = 1'b1;
        acked = 1'b1;
      end
      wait_cnt++;
    end else begin
      if (in_write && !acked) begin
        checks++;
        errors++;
        $display("FAIL we_dropped actual=0 required=1");
      end
      in_write = 1'b0;
    end
  end

  // UART tx responder: compares each status byte when it first appears
  bit tx_seen = 1'b0;
  int tx_wait = 0;

  always @(negedge clk) begin
    i_tx_ack = 1'b0;
    if (rst) begin
      tx_seen = 1'b0;
    end else if (o_tx_valid) begin
      if (!tx_seen) begin
        tx_seen = 1'b1;
        tx_wait = 0;
        last_tx = o_tx_data;
        if (exp_tx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx actual=%h required=none", o_tx_data);
        end else begin
          check32("tx_data", 32'(o_tx_data), 32'(exp_tx_q.pop_front()));
        end
      end
      if (tx_wait == tx_delay) i_tx_ack = 1'b1;
      tx_wait++;
    end else begin
      tx_seen = 1'b0;
    end
  end

  // the core must stay in reset until a start frame completes
  always @(negedge clk) begin
    if (!rst && !started) check32("core_rst_held", 32'(o_core_rst), 32'd1);
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    i_rx_fresh = 1'b1;
    i_rx_data  = b;
    @(negedge clk);
    i_rx_fresh = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], GAP);
  endtask

  // model: write i goes to aligned base + 4*i (mod 2^32); status is sum==C
  task automatic load_frame(input logic [31:0] n, input logic [31:0] a,
                            input logic [31:0] c, input bit expect_on);
    logic [31:0] sum;
    sum = 32'd0;
    for (int i = 0; i < int'(n); i++) begin
      if (expect_on) begin
        exp_addr_q.push_back((a & 32'hFFFF_FFFC) + 32'(i * 4));
        exp_data_q.push_back(frame_words[i]);
      end
      sum = sum + frame_words[i];
    end
    if (expect_on) exp_tx_q.push_back((sum == c) ? 8'h01 : 8'h00);
    send_byte(8'h10, GAP);
    send_word(n);
    send_word(a);
    send_word(c);
    for (int i = 0; i < int'(n); i++) send_word(frame_words[i]);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_tx_q.size() != 0 || exp_addr_q.size() != 0 || o_busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL %s_timeout actual=busy required=idle", name);
    end
  endtask

  task automatic send_start(input logic [31:0] p, input logic [31:0] exp_pc);
    send_byte(8'h20, GAP);
    for (int k = 0; k < 3; k++) send_byte(p[8*k +: 8], GAP);
    send_byte(p[31:24], 0);
    started = 1'b1;
    @(negedge clk);
    check32("start_core_rst", 32'(o_core_rst), 32'd0);
    check32("start_pc", o_start_pc, exp_pc);
    check32("start_busy", 32'(o_busy), 32'd0);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check32("rst_core_rst", 32'(o_core_rst), 32'd1);
    check32("rst_mem_we", 32'(o_mem_we), 32'd0);
    check32("rst_busy", 32'(o_busy), 32'd0);
    check32("rst_start_pc", o_start_pc, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    started = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    rst = 1'b1;
    i_rx_fresh = 1'b0;
    i_rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check32("reset_tx_data", 32'(o_tx_data), 32'd0);
    check32("reset_tx_valid", 32'(o_tx_valid), 32'd0);
    check32("reset_mem_addr", o_mem_addr, 32'd0);
    check32("reset_mem_wdata", o_mem_wdata, 32'd0);
    check32("reset_mem_we", 32'(o_mem_we), 32'd0);
    check32("reset_core_rst", 32'(o_core_rst), 32'd1);
    check32("reset_start_pc", o_start_pc, 32'd0);
    check32("reset_busy", 32'(o_busy), 32'd0);
    rst = 1'b0;

    // single-word load
    w0 = write_cnt;
    frame_words = '{32'hDEAD_BEEF};
    load_frame(32'd1, 32'h0000_0400, 32'hDEAD_BEEF, 1'b1);
    wait_done("load1");
    check32("load1_writes", 32'(write_cnt - w0), 32'd1);
    check32("load1_addr", o_mem_addr, 32'h0000_0400);
    check32("load1_data", o_mem_wdata, 32'hDEAD_BEEF);
    check32("load1_status", 32'(last_tx), 32'h01);
    check32("load1_core_rst", 32'(o_core_rst), 32'd1);

    // start, then bytes in RUN are ignored, then reset
    send_start(32'h0000_0400, 32'h0000_0400);
    w0 = write_cnt;
    frame_words = '{32'h1111_1111};
    load_frame(32'd1, 32'h0000_0800, 32'h1111_1111, 1'b0);
    send_byte(8'h33, GAP);
    repeat (20) @(negedge clk);
    check32("run_writes", 32'(write_cnt - w0), 32'd0);
    check32("run_core_rst", 32'(o_core_rst), 32'd0);
    do_reset();

    // bad checksum with slow memory acknowledgements
    ack_delay = 5;
    w0 = write_cnt;
    frame_words = '{32'd1, 32'd2, 32'd3};
    load_frame(32'd3, 32'h0000_1000, 32'h0000_0007, 1'b1);
    wait_done("badsum");
    ack_delay = 0;
    check32("badsum_writes", 32'(write_cnt - w0), 32'd3);
    check32("badsum_last_addr", o_mem_addr, 32'h0000_1008);
    check32("badsum_status", 32'(last_tx), 32'h00);

    // empty loads
    w0 = write_cnt;
    load_frame(32'd0, 32'h0000_2000, 32'd0, 1'b1);
    wait_done("n0_ok");
    check32("n0_ok_status", 32'(last_tx), 32'h01);
    load_frame(32'd0, 32'h0000_2000, 32'd5, 1'b1);
    wait_done("n0_bad");
    check32("n0_bad_status", 32'(last_tx), 32'h00);
    check32("n0_writes", 32'(write_cnt - w0), 32'd0);

    // misaligned base and address wrap
    frame_words = '{32'h1234_5678};
    load_frame(32'd1, 32'h0000_0403, 32'h1234_5678, 1'b1);
    wait_done("misalign");
    check32("misalign_addr", o_mem_addr, 32'h0000_0400);
    frame_words = '{32'h0000_000A, 32'h0000_000B};
    load_frame(32'd2, 32'hFFFF_FFFC, 32'h0000_0015, 1'b1);
    wait_done("wrap");
    check32("wrap_addr", o_mem_addr, 32'h0000_0000);
    check32("wrap_status", 32'(last_tx), 32'h01);

    // unknown command
    exp_tx_q.push_back(8'hFF);
    send_byte(8'h33, GAP);
    wait_done("unknown");
    check32("unknown_status", 32'(last_tx), 32'hFF);

    // inter-byte timeout, then a clean load
    send_byte(8'h10, GAP);
    send_byte(8'h01, GAP);
    send_byte(8'h00, 0);
    repeat (30) @(negedge clk);
    check32("tmo_busy_before", 32'(o_busy), 32'd1);
    repeat (15) @(negedge clk);
    check32("tmo_busy_after", 32'(o_busy), 32'd0);
    frame_words = '{32'hCAFE_F00D};
    load_frame(32'd1, 32'h0000_0500, 32'hCAFE_F00D, 1'b1);
    wait_done("after_tmo");
    check32("after_tmo_status", 32'(last_tx), 32'h01);
    check32("after_tmo_addr", o_mem_addr, 32'h0000_0500);

    // reset while a write is pending
    ack_delay = 30;
    exp_addr_q.push_back(32'h0000_3000);
    exp_data_q.push_back(32'h0000_0055);
    send_byte(8'h10, GAP);
    send_word(32'd1);
    send_word(32'h0000_3000);
    send_word(32'h0000_0055);
    send_word(32'h0000_0055);
    begin
      int n;
      n = 0;
      while (!o_mem_we && n < 20) begin
        @(negedge clk);
        n++;
      end
      check32("pending_write_seen", 32'(o_mem_we), 32'd1);
    end
    do_reset();
    ack_delay = 0;

    // start at a misaligned PC
    send_start(32'h0000_0206, 32'h0000_0204);
    do_reset();

    check32("left_writes", 32'(exp_addr_q.size()), 32'd0);
    check32("left_tx", 32'(exp_tx_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- CPU-side responder for the host programmer's UART boot protocol. Sits between the CPU's internal UART and the core/memory.
- Parses CMD_LOAD frames and writes the payload words into memory, then returns a one-byte status.
- Parses CMD_START, then releases the core from reset at the requested PC.
- Holds the core in reset from system reset until a valid CMD_START is received.

Parameters:
- TIMEOUT_CYCLES, 2500000, maximum idle cycles between bytes inside a frame (100 ms at 25 MHz) before the frame is aborted.
- CMD_LOAD, 8'h10, load command opcode.
- CMD_START, 8'h20, start command opcode.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous active-high reset
- i_rx_fresh  in  1  one-cycle pulse: new UART byte valid on i_rx_data
- i_rx_data  in  8  received byte
- o_tx_data  out  8  status byte to transmit
- o_tx_valid  out  1  transmit request
- i_tx_ack  in  1  UART accepted o_tx_data
- o_mem_addr  out  32  byte address, word aligned
- o_mem_wdata  out  32  write data
- o_mem_we  out  1  write request
- i_mem_ack  in  1  write completed
- o_core_rst  out  1  holds the core in reset while high
- o_start_pc  out  32  PC loaded into the core on release
- o_busy  out  1  high while a frame is in progress

Behaviour:
- Reset is asynchronous. Reset values: o_tx_data=0, o_tx_valid=0, o_mem_addr=0, o_mem_wdata=0, o_mem_we=0, o_core_rst=1, o_start_pc=0, o_busy=0. State is IDLE.
- All multi-byte fields are 32-bit little-endian (first byte received -> bits [7:0]).
- Bytes are consumed only on cycles where i_rx_fresh=1. A byte arriving in a state that does not accept one is dropped.
- States:
  - IDLE: on a byte equal to CMD_LOAD -> L_SIZE. On CMD_START -> S_ADDR. Any other byte -> STATUS with code 8'hFF.
  - L_SIZE: 4 bytes form the word count N.
  - L_ADDR: 4 bytes form the base address A. Bits [1:0] are forced to 0.
  - L_SUM: 4 bytes form the expected checksum C. The running sum is cleared. If N==0, go to L_CHECK; otherwise go to L_DATA.
  - L_DATA: assemble 4 bytes into word W, then go to L_WRITE.
  - L_WRITE: drive o_mem_addr=A+4*i, o_mem_wdata=W, o_mem_we=1. Hold all three until i_mem_ack=1. On the ack cycle: sum+=W (mod 2^32), i+=1, drop o_mem_we on the next cycle. If i==N go to L_CHECK, else return to L_DATA. Bytes arriving during L_WRITE are dropped; the host paces on status, and the UART rate guarantees a write completes before the next byte.
  - L_CHECK (1 cycle): status = 8'h01 if sum==C, else 8'h00. Go to STATUS. Words already written are not rolled back.
  - STATUS: set o_tx_data=status and o_tx_valid=1. Hold both until i_tx_ack=1. o_tx_valid=0 the cycle after the ack, then go to IDLE.
  - S_ADDR: 4 bytes form P. Then set o_start_pc=P[31:2],2'b00 and, one cycle later, o_core_rst=0. Go to RUN. No status byte is sent for START.
  - RUN: terminal state. All UART input is ignored and o_core_rst stays 0. Only i_rst leaves RUN.
- Address arithmetic wraps modulo 2^32. A+4*i past 32'hFFFFFFFC wraps to 0.
- Timeout:
  - A counter clears on every accepted byte and increments in L_SIZE, L_ADDR, L_SUM, L_DATA and S_ADDR.
  - When it reaches TIMEOUT_CYCLES the bootloader returns to IDLE with no status and o_mem_we=0.
  - The counter does not run in L_WRITE or STATUS.
- o_busy=1 in every state except IDLE and RUN.
- i_rst asserted mid-frame or mid-write: immediate return to reset values. Partial writes may have occurred. o_core_rst is forced back to 1.
- Simultaneous i_rx_fresh and i_tx_ack in STATUS: the ack is honoured and the byte is dropped.

Test Plan:
- Single-word load: send 10 | 01 00 00 00 | 00 04 00 00 | EF BE AD DE | EF BE AD DE -> exactly one write, addr=0x400, data=0xDEADBEEF; status byte 0x01; o_core_rst stays 1.
- Start after load: send 20 | 00 04 00 00 -> o_start_pc=0x400; o_core_rst falls within 2 cycles of the last byte; no tx byte. Further bytes produce no writes and no tx. Asserting i_rst -> o_core_rst=1, state IDLE.
- Bad checksum: 3-word load at 0x1000 with data 1,2,3 and C=0x00000007 -> writes to 0x1000, 0x1004, 0x1008; status 0x00.
- Edge sizes and stalls:
  - N=0 with C=0 -> no writes, status 0x01.
  - N=0 with C=5 -> status 0x00.
  - i_mem_ack delayed 5 cycles -> o_mem_we/addr/data held stable throughout.
- Unknown command and misalignment: byte 0x33 -> status 0xFF. A load with A=0x403 -> first write at 0x400. A start with P=0x206 -> o_start_pc=0x204.
- Timeout and reset: send 10 01 00 then idle for TIMEOUT_CYCLES -> back to IDLE, o_busy=0, no tx; a following full valid load succeeds. Separately, i_rst during L_WRITE -> o_mem_we=0 asynchronously.
